// File: rtl/hex_scroller.sv
// Scrolling message controller for six seven-segment displays: an 8-nibble
// circular buffer shown through a 6-digit window that steps every DIV cycles.
module hex_scroller #(
    parameter int unsigned DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       start,
    input  logic       stop,
    input  logic       dir,
    output logic       busy,
    output logic       tick,
    output logic [2:0] pos,
    output logic [6:0] HEX5,
    output logic [6:0] HEX4,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [6:0]    BLANK    = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    pos_q, pos_d;
    logic          tick_q, tick_d;
    logic          busy_q, busy_d;
    logic [3:0]    msg_q [8];
    logic [3:0]    msg_d [8];
    logic [6:0]    hex_q [6];
    logic [6:0]    hex_d [6];

    // Active-low segments, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pos_d   = pos_q;
        tick_d  = 1'b0;
        msg_d   = msg_q;
        if (wr_en) begin
            msg_d[wr_addr] = wr_data;
        end

        case (state_q)
            IDLE: begin
                div_d = '0;
                if (start && !stop) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // The step on terminal count happens even if stop arrives the same cycle.
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    tick_d = 1'b1;
                    pos_d  = dir ? (pos_q - 3'd1) : (pos_q + 3'd1);
                end else begin
                    div_d = div_q + DW'(1);
                end
                if (stop) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (start && !stop) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);

        for (int i = 0; i < 6; i++) begin
            hex_d[i] = (state_q == IDLE) ? BLANK : seg7(msg_q[pos_q + 3'(5 - i)]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race with readers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            pos_q   <= '0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            // NOTE: the message buffer is architecturally visible, so it is reset like any other register.
            msg_q   <= '{default: '0};
            hex_q   <= '{default: BLANK};
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pos_q   <= pos_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            msg_q   <= msg_d;
            hex_q   <= hex_d;
        end
    end

    assign busy = busy_q;
    assign tick = tick_q;
    assign pos  = pos_q;
    assign HEX5 = hex_q[5];
    assign HEX4 = hex_q[4];
    assign HEX3 = hex_q[3];
    assign HEX2 = hex_q[2];
    assign HEX1 = hex_q[1];
    assign HEX0 = hex_q[0];

endmodule

// File: tb/tb_hex_scroller.sv
// Directed bench for hex_scroller with DIV=4; expected values hand-derived
// from the cycle timing of the scroller, checked with immediate assertions.
module tb_hex_scroller;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       start;
    logic       stop;
    logic       dir;
    logic       busy;
    logic       tick;
    logic [2:0] pos;
    logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;

    int errors = 0;
    int checks = 0;

    hex_scroller #(.DIV(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .stop    (stop),
        .dir     (dir),
        .busy    (busy),
        .tick    (tick),
        .pos     (pos),
        .HEX5    (hex5),
        .HEX4    (hex4),
        .HEX3    (hex3),
        .HEX2    (hex2),
        .HEX1    (hex1),
        .HEX0    (hex0)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_window(input string tag,
                                input logic [6:0] e5, input logic [6:0] e4, input logic [6:0] e3,
                                input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
        check({tag, "_hex5"}, hex5, e5);
        check({tag, "_hex4"}, hex4, e4);
        check({tag, "_hex3"}, hex3, e3);
        check({tag, "_hex2"}, hex2, e2);
        check({tag, "_hex1"}, hex1, e1);
        check({tag, "_hex0"}, hex0, e0);
    endtask

    // Three quiet cycles then a tick landing on exp_pos.
    task automatic run_tick(input string tag, input logic [2:0] exp_pos);
        repeat (3) step();
        check({tag, "_pre_tick"}, tick, 1'b0);
        step();
        check({tag, "_tick"}, tick, 1'b1);
        check({tag, "_pos"}, pos, exp_pos);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'h9;
        start = 1'b0; stop = 1'b0; dir = 1'b0;

        // Reset held two cycles with a write attempted
        step(); step();
        check_window("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        check("reset_pos", pos, 3'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_tick", tick, 1'b0);
        reset = 1'b0; wr_en = 1'b0;

        // start+stop together in IDLE does nothing
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        check("idle_start_stop_busy", busy, 1'b0);
        step();
        check("idle_blank", hex5, 7'h7F);

        // Buffer is all zeros once visible
        start = 1'b1; step(); start = 1'b0;
        check("start0_busy", busy, 1'b1);
        check("start0_hex_not_yet", hex5, 7'h7F);
        step();
        check_window("zero_buf", 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
        reset = 1'b1; step(); reset = 1'b0;
        check("rereset_busy", busy, 1'b0);
        check("rereset_hex5", hex5, 7'h7F);
        check("rereset_pos", pos, 3'd0);

        // Load 1..8 and start
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i + 1);
            step();
        end
        wr_en = 1'b0;
        check("load_idle_blank", hex5, 7'h7F);
        start = 1'b1; step(); start = 1'b0;
        check("run_busy", busy, 1'b1);
        step();
        check_window("first", 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02);
        check("first_tick_low1", tick, 1'b0);
        step(); step();
        check("first_tick_low3", tick, 1'b0);
        step();
        check("first_tick", tick, 1'b1);
        check("first_pos", pos, 3'd1);
        step();
        check("after_tick_hex5", hex5, 7'h24);
        check("tick_width", tick, 1'b0);
        step(); step(); step();
        check("tick2", tick, 1'b1);
        check("tick2_pos", pos, 3'd2);
        for (int p = 3; p <= 6; p++) begin
            run_tick("wrap", 3'(p));
        end

        // Window wrap-around at pos=6, dir glitch mid-period
        step();
        check_window("wrap6", 7'h78, 7'h00, 7'h79, 7'h24, 7'h30, 7'h19);
        dir = 1'b1; step();
        check("dir_glitch_pos", pos, 3'd6);
        dir = 1'b0; step(); step();
        check("pos7_tick", tick, 1'b1);
        check("pos7", pos, 3'd7);
        run_tick("wrap_to0", 3'd0);
        dir = 1'b1;
        run_tick("dec_to7", 3'd7);

        // Hold two cycles after a tick, then resume
        step();
        stop = 1'b1; step(); stop = 1'b0;
        check("hold_busy", busy, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("hold_tick", tick, 1'b0);
            check("hold_pos", pos, 3'd7);
        end
        check("hold_busy_end", busy, 1'b0);
        check_window("hold_win", 7'h00, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12);
        start = 1'b1; step(); start = 1'b0;
        check("resume_busy", busy, 1'b1);
        check("resume_tick0", tick, 1'b0);
        step();
        check("resume_tick1", tick, 1'b0);
        step();
        check("resume_tick", tick, 1'b1);
        check("resume_pos", pos, 3'd6);

        // start+stop together in RUN goes to HOLD
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        check("ss_run_busy", busy, 1'b0);
        repeat (3) step();
        check("ss_run_tick", tick, 1'b0);
        check("ss_run_pos", pos, 3'd6);
        check("ss_run_busy2", busy, 1'b0);

        // stop on the terminal-count cycle: last step still happens
        start = 1'b1; step(); start = 1'b0;
        check("tc_busy", busy, 1'b1);
        step(); step();
        check("tc_pre", tick, 1'b0);
        stop = 1'b1; step(); stop = 1'b0;
        check("tc_tick", tick, 1'b1);
        check("tc_pos", pos, 3'd5);
        check("tc_busy_hold", busy, 1'b0);
        step();
        check("tc_after_tick", tick, 1'b0);
        check("tc_after_pos", pos, 3'd5);

        // start+stop together in HOLD stays in HOLD
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        check("ss_hold_busy", busy, 1'b0);
        repeat (5) step();
        check("ss_hold_pos", pos, 3'd5);
        check("ss_hold_tick", tick, 1'b0);
        check_window("pos5", 7'h02, 7'h78, 7'h00, 7'h79, 7'h24, 7'h30);

        // Move to pos=0 and freeze there with stop on terminal count
        dir = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        run_tick("to6", 3'd6);
        run_tick("to7", 3'd7);
        repeat (3) step();
        stop = 1'b1; step(); stop = 1'b0;
        check("to0_tick", tick, 1'b1);
        check("to0_pos", pos, 3'd0);
        check("to0_busy", busy, 1'b0);
        step();
        check_window("pos0", 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02);

        // Live write into a visible slot during HOLD
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hF; step(); wr_en = 1'b0;
        check("live_latency", hex3, 7'h30);
        step();
        check("live_hex3", hex3, 7'h0E);
        check("live_hex5", hex5, 7'h79);
        check("live_pos", pos, 3'd0);
        start = 1'b1; step(); start = 1'b0;
        run_tick("live_div", 3'd1);

        // Reset mid-run overrides a simultaneous write
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h7; reset = 1'b1;
        step();
        reset = 1'b0; wr_en = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_tick", tick, 1'b0);
        check("midrst_pos", pos, 3'd0);
        check("midrst_hex5", hex5, 7'h7F);
        start = 1'b1; step(); start = 1'b0;
        step();
        check_window("midrst_buf", 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hex_scroller.md
# hex_scroller

Scrolling message controller for the six on-board seven-segment displays (HEX5..HEX0). It holds an 8-nibble circular message buffer loaded through a simple write port. In RUN it advances a window position at a rate set by an internal rate divider, and drives each display through the team's hex-to-seven-segment decoder (digits 0–F, active-low segments). It sits between the switch/key input logic and the HEX pins in the lab top level.

## Interface
- DIV, default 50000000: rate-divider terminal count; one scroll step every DIV clock cycles (1 Hz at 50 MHz); legal range 2..2^26.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe for the message buffer.
- wr_addr  input  3  buffer slot to write (0..7).
- wr_data  input  4  hex nibble to store.
- start  input  1  single-cycle pulse; begin or resume scrolling.
- stop  input  1  single-cycle pulse; freeze scrolling.
- dir  input  1  0 = position increments (text moves left); 1 = position decrements.
- busy  output  1  high in RUN.
- tick  output  1  single-cycle pulse on the cycle the position advances.
- pos  output  3  current window start slot.
- HEX5..HEX0  output  7 each  registered active-low segment patterns, bit 0 = segment a … bit 6 = segment g.

## Operation
- Buffer: 8×4-bit registers, all cleared to 0 by reset. A write is accepted in every state. When wr_en is high, buf[wr_addr] <= wr_data at that edge.
- Window mapping: HEX5 = dec(buf[pos]), HEX4 = dec(buf[pos+1]), … HEX0 = dec(buf[pos+5]). All indices mod 8, so wrap-around is natural; e.g. pos=6 shows slots 6,7,0,1,2,3.
- States: IDLE, RUN, HOLD.
  - IDLE: all HEX = 7'h7F (blank); divider held at 0. start → RUN with the divider cleared; pos is not changed.
  - RUN: divider counts 0..DIV-1. On count DIV-1, tick=1, the divider wraps to 0, and pos <= pos+1 (dir=0) or pos-1 (dir=1) mod 8. stop → HOLD.
  - HOLD: the window is displayed but frozen. Divider and pos hold their values. start → RUN, and the divider resumes from its held count.
- There is no path back to IDLE except reset.
- Simultaneous start and stop: stop wins. In RUN → HOLD; in IDLE the pulse has no effect; in HOLD the block stays in HOLD.
- stop arriving on the same cycle as the divider's terminal count: the step still occurs (pos advances, tick=1) and the state becomes HOLD.
- dir is sampled only on the tick cycle. It may change at any time without glitching pos.
- A write to a slot currently in the window is displayed per the latency rule below. It does not disturb pos or the divider.

## Timing
- Reset values: state IDLE, pos=0, divider=0, tick=0, busy=0, all HEX=7'h7F, buffer all 0.
- Reset asserted mid-operation takes effect at the next edge and overrides all other inputs, including a simultaneous wr_en.
- busy is registered and follows the state: high from the first cycle after the start edge.
- HEX outputs are registered from the buffer and pos: one edge of latency after a buffer or pos update. A write sampled at edge n appears on HEX at edge n+1.
- First step after start from IDLE: tick is high DIV cycles after the start edge. pos changes at that edge, and HEX reflects the new pos one edge later.
- Steady RUN: tick period is exactly DIV cycles, pulse width 1 cycle.
- Entering RUN from IDLE: the HEX window appears at the edge after the state becomes RUN. Entering HOLD never blanks the displays.

## Test plan
- Reset check: assert reset for 2 cycles with wr_en=1. Required: every HEX=7'h7F, pos=0, busy=0, tick=0, and the buffer still all zeros when viewed after start.
- Load and first display: with DIV=4, write slots 0..7 = 1,2,3,4,5,6,7,8, then pulse start. Required: HEX5..HEX0 = dec(1..6), i.e. HEX5=7'h79, HEX4=7'h24. First tick exactly 4 cycles after start, then pos=1 and HEX5=7'h24.
- Wrap-around: with DIV=4, run dir=0 for 6 ticks. Required: pos=6 and the window shows slots 6,7,0,1,2,3 (digits 7,8,1,2,3,4). With dir=1 from pos=0, one tick gives pos=7.
- Hold and resume: pulse stop 2 cycles after a tick, wait 20 cycles, then pulse start. Required: pos unchanged and tick=0 throughout HOLD, busy=0. The next tick arrives 2 cycles after the start edge because the divider resumes from its held count.
- Simultaneous events: start and stop in the same cycle from RUN gives HOLD. stop on the terminal-count cycle gives one final tick with pos advanced, then HOLD.
- Live write: in HOLD with pos=0, write slot 2 = 4'hF. Required: HEX3 becomes 7'h0E one edge later; pos and the divider are unchanged.
